// File: rtl/circuit_pipe.sv
// circuit_pipe: computes z = max/min(a+b, a+c) and x = a*c - (a+b), with optional signed arithmetic.
// Latency: 2 cycles from accept to out_valid. Throughput is 1 transaction per cycle.
// Backpressure: a stalled output holds z/x stable; in_ready drops only when both stages are full and stalled.
module circuit_pipe #(
  parameter int DATAWIDTH = 8,
  parameter bit SIGNED    = 1'b0,
  parameter int CNTWIDTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     c,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATAWIDTH-1:0]     z,
  output logic [2*DATAWIDTH-1:0]   x,
  output logic [CNTWIDTH-1:0]      done_cnt
);

  localparam int W  = DATAWIDTH;
  localparam int XW = 2 * DATAWIDTH;

  // Stage 1 holds the sums and the full-width product.
  logic          s1_valid;
  logic [W-1:0]  s1_d;
  logic [W-1:0]  s1_e;
  logic [XW-1:0] s1_f;
  logic          s1_mode;
  logic          s2_valid;

  logic          adv2;
  logic          accept;

  logic [W-1:0]  d_n;
  logic [W-1:0]  e_n;
  logic          a_sx;
  logic          c_sx;
  logic          d_sx;
  logic [XW-1:0] a_ext;
  logic [XW-1:0] c_ext;
  logic [XW-1:0] f_n;
  logic [XW-1:0] d_ext;
  logic          g;
  logic [W-1:0]  z_n;
  logic [XW-1:0] x_n;

  // Carries out of the W-bit sums are intentionally dropped.
  assign d_n = a + b;
  assign e_n = a + c;

  // Extending both operands to 2W bits (sign or zero) makes the truncated
  // unsigned product equal to the signed product modulo 2^(2W).
  assign a_sx  = SIGNED & a[W-1];
  assign c_sx  = SIGNED & c[W-1];
  assign a_ext = {{W{a_sx}}, a};
  assign c_ext = {{W{c_sx}}, c};
  assign f_n   = a_ext * c_ext;

  assign d_sx  = SIGNED & s1_d[W-1];
  assign d_ext = {{W{d_sx}}, s1_d};

  // Stage-2 compare and select; ties pick e, which equals d anyway.
  always_comb begin
    g = 1'b0;
    if (SIGNED) g = $signed(s1_d) > $signed(s1_e);
    else        g = s1_d > s1_e;
    z_n = (g ^ s1_mode) ? s1_d : s1_e;
    x_n = s1_f - d_ext;
  end

  // Stage 1 always moves with stage 2, so one advance term covers both.
  assign adv2      = !s2_valid || out_ready;
  assign in_ready  = Rst && (!s1_valid || adv2);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture operand-derived values on accept; empty out when drained without refill.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_e     <= '0;
      s1_f     <= '0;
      s1_mode  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_d    <= d_n;
        s1_e    <= e_n;
        s1_f    <= f_n;
        s1_mode <= mode;
      end
    end
  end

  // Stage 2: load results only when a valid stage-1 entry advances; bubbles keep old z/x.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s2_valid <= 1'b0;
      z        <= '0;
      x        <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        z <= z_n;
        x <= x_n;
      end
    end
  end

  // Count results taken by the sink; wraps naturally at 2^CNTWIDTH.
  always_ff @(posedge Clk) begin
    if (!Rst) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 1'b1;
  end

endmodule
